// File: rtl/ps2_keycode_rx.sv
// PS/2 device-to-host receiver: synchroniser, clock glitch filter, frame decoder,
// E0/F0 prefix folding and a key-event FIFO with a valid/ready consumer port.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for a start bit (data 0 on a PS_clk fall)
// S_DATA   | shifting in eight data bits, LSB first
// S_PARITY | capturing the parity bit
// S_STOP   | checking the stop bit, then reporting byte or error
module ps2_keycode_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int FIFO_DEPTH     = 8,
    parameter int PARITY_CHECK   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          PS_clk,
    input  logic                          PS_data,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_break,
    output logic                          evt_ext,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          ovf
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   sync_clk, sync_data;
    logic                   filt_clk, filt_next;
    logic [FW-1:0]          filt_cnt, filt_cnt_next;
    logic                   fall;

    state_t                 state, state_d;
    logic [2:0]             bit_cnt, bit_cnt_d;
    logic [7:0]             shreg, shreg_d;
    logic                   par_bit, par_d;
    logic [TW-1:0]          tmo_cnt, tmo_d;
    logic                   done_d, perr_d, ferr_d;
    logic                   byte_done;

    logic                   ext_flag, brk_flag;
    logic                   push, push_ok, pop;
    logic [9:0]             mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [9:0]             head;

    assign sync_clk  = clk_sync[SYNC_STAGES-1];
    assign sync_data = data_sync[SYNC_STAGES-1];

    // Two-or-more flop synchronisers; idle line level is 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], PS_data};
        end
    end

    // Filtered clock follows the synced clock only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_next     = filt_clk;
        filt_cnt_next = '0;
        if (sync_clk != filt_clk) begin
            if (filt_cnt == FILT_LAST) begin
                filt_next = sync_clk;
            end else begin
                filt_cnt_next = filt_cnt + FW'(1);
            end
        end
    end

    assign fall = filt_clk & ~filt_next;

    // Filter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else begin
            filt_clk <= filt_next;
            filt_cnt <= filt_cnt_next;
        end
    end

    // Frame decoder next-state; the timeout is a reloading down-counter.
    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        shreg_d   = shreg;
        par_d     = par_bit;
        done_d    = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        tmo_d     = (state == S_IDLE || fall) ? TMO_LOAD : tmo_cnt - TW'(1);
        if (fall) begin
            case (state)
                S_IDLE: begin
                    if (!sync_data) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shreg_d   = {sync_data, shreg[7:1]};
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = sync_data;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!sync_data) begin
                        ferr_d = 1'b1;
                    end else if (PARITY_CHECK != 0 && !(^{shreg, par_bit})) begin
                        perr_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state != S_IDLE && tmo_cnt == '0) begin
            state_d = S_IDLE;
            ferr_d  = 1'b1;
        end
    end

    // Frame decoder registers and registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            tmo_cnt    <= TMO_LOAD;
            byte_done  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_d;
            bit_cnt    <= bit_cnt_d;
            shreg      <= shreg_d;
            par_bit    <= par_d;
            tmo_cnt    <= tmo_d;
            byte_done  <= done_d;
            parity_err <= perr_d;
            frame_err  <= ferr_d;
        end
    end

    // shreg is still the completed byte while byte_done is high.
    assign push    = byte_done && shreg != 8'hE0 && shreg != 8'hF0;
    assign pop     = evt_valid & evt_ready;
    assign push_ok = push & ((fifo_level != DEPTH_L) | pop);

    // Prefix flags: set by E0/F0, cleared by any pushed key or any error.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else if (parity_err || frame_err || push) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else if (byte_done) begin
            if (shreg == 8'hE0) ext_flag <= 1'b1;
            if (shreg == 8'hF0) brk_flag <= 1'b1;
        end
    end

    // Event storage; contents need no reset since the outputs are gated by evt_valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {ext_flag, brk_flag, shreg};
    end

    // FIFO pointers, level and overflow pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            ovf        <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
            ovf <= push & ~push_ok;
        end
    end

    assign head      = mem[rd_ptr];
    assign evt_valid = (fifo_level != '0);
    assign evt_code  = evt_valid ? head[7:0] : 8'h00;
    assign evt_break = evt_valid & head[8];
    assign evt_ext   = evt_valid & head[9];

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx. dut1: FILTER_LEN=1, FIFO_DEPTH=4, parity checked.
// dut2: FILTER_LEN=4, FIFO_DEPTH=8, parity ignored. Both share the PS/2 lines.
module tb_ps2_keycode_rx;

    localparam int HALF = 10;
    localparam int TMO  = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps_clk = 1'b1;
    logic       ps_data = 1'b1;
    logic       ready1 = 1'b0;
    logic       ready2 = 1'b1;

    logic       v1, brk1, ext1, perr1, ferr1, ovf1;
    logic [7:0] code1;
    logic [2:0] lvl1;
    logic       v2, brk2, ext2, perr2, ferr2, ovf2;
    logic [7:0] code2;
    logic [3:0] lvl2;

    logic [9:0] cap1[$];
    logic [9:0] cap2[$];
    int rd1 = 0, rd2 = 0;
    int np1 = 0, nf1 = 0, no1 = 0, np2 = 0, nf2 = 0, no2 = 0;
    int bp1, bf1, bo1, bp2, bf2, bo2;
    int n_cmp = 0, n_mis = 0;

    ps2_keycode_rx #(.SYNC_STAGES(2), .FILTER_LEN(1), .TIMEOUT_CYCLES(TMO),
                     .FIFO_DEPTH(4), .PARITY_CHECK(1)) dut1 (
        .clk(clk), .rst(rst), .PS_clk(ps_clk), .PS_data(ps_data),
        .evt_valid(v1), .evt_ready(ready1), .evt_code(code1), .evt_break(brk1),
        .evt_ext(ext1), .fifo_level(lvl1), .parity_err(perr1), .frame_err(ferr1), .ovf(ovf1)
    );

    ps2_keycode_rx #(.SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TMO),
                     .FIFO_DEPTH(8), .PARITY_CHECK(0)) dut2 (
        .clk(clk), .rst(rst), .PS_clk(ps_clk), .PS_data(ps_data),
        .evt_valid(v2), .evt_ready(ready2), .evt_code(code2), .evt_break(brk2),
        .evt_ext(ext2), .fifo_level(lvl2), .parity_err(perr2), .frame_err(ferr2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    // Record popped events and count status pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (v1 && ready1) cap1.push_back({ext1, brk1, code1});
        if (v2 && ready2) cap2.push_back({ext2, brk2, code2});
        if (perr1) np1++;
        if (ferr1) nf1++;
        if (ovf1)  no1++;
        if (perr2) np2++;
        if (ferr2) nf2++;
        if (ovf2)  no2++;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap_errs();
        bp1 = np1; bf1 = nf1; bo1 = no1;
        bp2 = np2; bf2 = nf2; bo2 = no2;
    endtask

    task automatic check_errs(input string tag, input int dp1, input int df1, input int do1,
                              input int dp2, input int df2);
        check_val({tag, "_perr1"}, np1 - bp1, dp1);
        check_val({tag, "_ferr1"}, nf1 - bf1, df1);
        check_val({tag, "_ovf1"},  no1 - bo1, do1);
        check_val({tag, "_perr2"}, np2 - bp2, dp2);
        check_val({tag, "_ferr2"}, nf2 - bf2, df2);
    endtask

    task automatic check_evt1(input string tag, input logic [9:0] exp);
        check_val({tag, "_present1"}, int'(cap1.size() > rd1), 1);
        if (cap1.size() > rd1) begin
            check_val({tag, "_evt1"}, int'(cap1[rd1]), int'(exp));
            rd1++;
        end
    endtask

    task automatic check_evt2(input string tag, input logic [9:0] exp);
        check_val({tag, "_present2"}, int'(cap2.size() > rd2), 1);
        if (cap2.size() > rd2) begin
            check_val({tag, "_evt2"}, int'(cap2[rd2]), int'(exp));
            rd2++;
        end
    endtask

    task automatic check_none(input string tag);
        check_val({tag, "_extra1"}, cap1.size() - rd1, 0);
        check_val({tag, "_extra2"}, cap2.size() - rd2, 0);
    endtask

    task automatic send_bit(input logic b);
        ps_data = b;
        tick(HALF);
        ps_clk = 1'b0;
        tick(HALF);
        ps_clk = 1'b1;
    endtask

    // Full 11-bit frame; optional latency check on dut1 around the stop-bit fall.
    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_b,
                              input logic lat_chk);
        logic [9:0] bits;
        bits = {(~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < 10; i++) send_bit(bits[i]);
        ps_data = stop_b;
        tick(HALF);
        ps_clk = 1'b0;
        if (lat_chk) begin
            tick(3);
            check_val("lat_valid_early", int'(v1), 0);
            tick(1);
            check_val("lat_valid_on_time", int'(v1), 1);
            tick(HALF - 4);
        end else begin
            tick(HALF);
        end
        ps_clk  = 1'b1;
        ps_data = 1'b1;
        tick(HALF);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        logic [7:0] d;
        d = b;
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
        ps_data = 1'b1;
    endtask

    initial begin
        logic [7:0] seq2 [9];
        logic [9:0] exp2 [6];
        logic [7:0] seq6 [5];
        seq2 = '{8'h3E, 8'hF0, 8'h3E, 8'h79, 8'hF0, 8'h79, 8'h5A, 8'hF0, 8'h5A};
        exp2 = '{10'h03E, 10'h13E, 10'h079, 10'h179, 10'h05A, 10'h15A};
        seq6 = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};

        tick(5);
        check_val("rst_valid1", int'(v1), 0);
        check_val("rst_level1", int'(lvl1), 0);
        check_val("rst_level2", int'(lvl2), 0);
        check_val("rst_code1", int'(code1), 0);
        check_val("rst_flags1", int'({brk1, ext1, perr1, ferr1, ovf1}), 0);
        rst = 1'b0;
        tick(5);

        // Single make code, head held with ready low.
        snap_errs();
        send_frame(8'h3E, 1'b0, 1'b1, 1'b1);
        check_val("t1_valid", int'(v1), 1);
        check_val("t1_code", int'(code1), 'h3E);
        check_val("t1_break", int'(brk1), 0);
        check_val("t1_ext", int'(ext1), 0);
        check_val("t1_level", int'(lvl1), 1);
        tick(3);
        check_val("t1_hold_code", int'(code1), 'h3E);
        ready1 = 1'b1;
        tick(2);
        check_val("t1_drained", int'(lvl1), 0);
        check_evt1("t1", 10'h03E);
        check_evt2("t1", 10'h03E);

        // Make/break sequences.
        for (int i = 0; i < 9; i++) send_frame(seq2[i], 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check_evt1($sformatf("t2_%0d", i), exp2[i]);
            check_evt2($sformatf("t2_%0d", i), exp2[i]);
        end
        check_none("t2");
        check_errs("t2", 0, 0, 0, 0, 0);

        // Extended break: E0 F0 75 folds to one event.
        send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h75, 1'b0, 1'b1, 1'b0);
        check_evt1("t3", 10'h375);
        check_evt2("t3", 10'h375);
        check_none("t3");

        // Bad parity after F0: dut1 drops it and the break flag; dut2 accepts it.
        snap_errs();
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h3E, 1'b1, 1'b1, 1'b0);
        send_frame(8'h3E, 1'b0, 1'b1, 1'b0);
        check_evt1("t4_after_perr", 10'h03E);
        check_evt2("t4_noparity_a", 10'h13E);
        check_evt2("t4_noparity_b", 10'h03E);
        check_none("t4");
        check_errs("t4_par", 1, 0, 0, 0, 0);

        // Stop bit 0.
        snap_errs();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        check_none("t4_stop");
        check_errs("t4_stop", 0, 1, 0, 0, 1);

        // Clock stops after data bit 3.
        snap_errs();
        send_partial(8'h5A, 4);
        tick(TMO + 20);
        check_errs("t5_tmo", 0, 1, 0, 0, 1);
        check_none("t5_tmo");
        send_frame(8'h5A, 1'b0, 1'b0 ^ 1'b1, 1'b0);
        check_evt1("t5_recover", 10'h05A);
        check_evt2("t5_recover", 10'h05A);

        // Overflow on dut1 (depth 4) with the consumer stalled.
        ready1 = 1'b0;
        snap_errs();
        for (int i = 0; i < 4; i++) send_frame(seq6[i], 1'b0, 1'b1, 1'b0);
        check_val("t6_level4", int'(lvl1), 4);
        check_val("t6_no_ovf_yet", no1 - bo1, 0);
        send_frame(seq6[4], 1'b0, 1'b1, 1'b0);
        check_val("t6_level_full", int'(lvl1), 4);
        check_val("t6_ovf", no1 - bo1, 1);
        check_val("t6_head", int'(code1), 'h16);
        ready1 = 1'b1;
        tick(6);
        for (int i = 0; i < 4; i++) check_evt1($sformatf("t6_%0d", i), {2'b00, seq6[i]});
        for (int i = 0; i < 5; i++) check_evt2($sformatf("t6_%0d", i), {2'b00, seq6[i]});
        check_none("t6");

        // Reset in the middle of a frame.
        ready1 = 1'b0;
        snap_errs();
        send_frame(8'h1E, 1'b0, 1'b1, 1'b0);
        check_val("t7_level_before", int'(lvl1), 1);
        send_partial(8'h29, 4);
        rst = 1'b1;
        tick(3);
        check_val("t7_level_rst", int'(lvl1), 0);
        check_val("t7_valid_rst", int'(v1), 0);
        rst = 1'b0;
        ready1 = 1'b1;
        tick(5);
        send_frame(8'h29, 1'b0, 1'b1, 1'b0);
        check_evt1("t7_after_rst", 10'h029);
        check_evt2("t7_pre_rst", 10'h01E);
        check_evt2("t7_after_rst", 10'h029);
        check_none("t7");
        check_errs("t7", 0, 0, 0, 0, 0);
        check_val("ovf2_never", no2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
